conway_ctrl: RTL and testbench

Generation sequencer for the Conway life datapath. It walks the row-update engine across the grid one row at a time and commits each finished generation by swapping the double-buffered grid. It then handshakes the finished frame out to the display scanner and paces generations with a programmable hold timer. It sits between the host control bits (run/step/clear) and the row engine plus display, owns the generation counter, and auto-halts when the pattern stops changing.

---
 rtl/conway_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_conway_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_ctrl.sv
// conway_ctrl: generation sequencer for the Conway life datapath.
//
// Steps the row-update engine through every row of the grid. When the last
// row is done it commits the generation by swapping the double-buffered grid.
// It then hands the frame to the display scanner and waits out a programmable
// hold period before the next generation. Free-run stops on its own once a
// committed generation contains no changed rows.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   run_en       level, free-run generations while high
//   step         pulse, run one generation from IDLE
//   clear        pulse, synchronous abort plus counter/flag clear
//   period       hold cycles between generations, sampled on HOLD entry
//   row_done     engine pulse, issued row finished
//   row_changed  qualified by row_done, row differs from the previous generation
//   disp_ack     display accepted the committed frame
//   row_start    pulse, engine begins row row_idx
//   row_idx      current row, 0..GRID_W-1
//   buf_sel      read-buffer select; the engine writes !buf_sel
//   commit       pulse, generation complete
//   disp_req     level, frame ready for display
//   gen_count    completed generations, wraps
//   stable       last committed generation had no changed rows
//   busy         high in every state except IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for step, or run_en with a pattern that still changes
// ROW_ISSUE | row_start pulse for row row_idx
// ROW_WAIT  | waiting for the engine's row_done
// COMMIT    | commit pulse; buffers swap on the exit edge
// DISP      | disp_req held until disp_ack
// HOLD      | hold timer counts down from period to 0

module conway_ctrl #(
  parameter int GRID_W   = 60,
  parameter int PERIOD_W = 16,
  parameter int GEN_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_en,
  input  logic                step,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  input  logic                row_done,
  input  logic                row_changed,
  input  logic                disp_ack,
  output logic                row_start,
  output logic [7:0]          row_idx,
  output logic                buf_sel,
  output logic                commit,
  output logic                disp_req,
  output logic [GEN_W-1:0]    gen_count,
  output logic                stable,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ROW_ISSUE = 3'd1,
    S_ROW_WAIT  = 3'd2,
    S_COMMIT    = 3'd3,
    S_DISP      = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  localparam logic [7:0] LAST_ROW = 8'(GRID_W - 1);

  state_t              state_q, state_d;
  logic [7:0]          row_idx_q, row_idx_d;
  logic                buf_sel_q, buf_sel_d;
  logic [GEN_W-1:0]    gen_count_q, gen_count_d;
  logic                stable_q, stable_d;
  logic                acc_q, acc_d;        // any row changed this generation
  logic [PERIOD_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_idx_q   <= '0;
      buf_sel_q   <= 1'b0;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
      acc_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      buf_sel_q   <= buf_sel_d;
      gen_count_q <= gen_count_d;
      stable_q    <= stable_d;
      acc_q       <= acc_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    buf_sel_d   = buf_sel_q;
    gen_count_d = gen_count_q;
    stable_d    = stable_q;
    acc_d       = acc_q;
    timer_d     = timer_q;

    if (clear) begin
      // Abort wins over everything, including a row_done/disp_ack this cycle.
      state_d     = S_IDLE;
      row_idx_d   = '0;
      buf_sel_d   = 1'b0;
      gen_count_d = '0;
      stable_d    = 1'b0;
      acc_d       = 1'b0;
      timer_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // step runs a generation even on a stable pattern; free-run does not.
          if (step || (run_en && !stable_q)) begin
            state_d   = S_ROW_ISSUE;
            row_idx_d = '0;
            acc_d     = 1'b0;
          end
        end

        S_ROW_ISSUE: begin
          state_d = S_ROW_WAIT;
        end

        S_ROW_WAIT: begin
          if (row_done) begin
            acc_d = acc_q | row_changed;
            if (row_idx_q == LAST_ROW) begin
              state_d = S_COMMIT;
            end else begin
              row_idx_d = row_idx_q + 8'd1;
              state_d   = S_ROW_ISSUE;
            end
          end
        end

        S_COMMIT: begin
          buf_sel_d   = ~buf_sel_q;
          gen_count_d = gen_count_q + GEN_W'(1);
          stable_d    = ~acc_q;
          row_idx_d   = '0;
          state_d     = S_DISP;
        end

        S_DISP: begin
          // stable_q already reflects the generation just committed.
          if (disp_ack) begin
            if (!run_en || stable_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_HOLD;
              timer_d = period;
            end
          end
        end

        S_HOLD: begin
          if (timer_q == '0) begin
            if (run_en && !stable_q) begin
              state_d   = S_ROW_ISSUE;
              row_idx_d = '0;
              acc_d     = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            timer_d = timer_q - PERIOD_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign row_start = (state_q == S_ROW_ISSUE);
  assign commit    = (state_q == S_COMMIT);
  assign disp_req  = (state_q == S_DISP);
  assign busy      = (state_q != S_IDLE);
  assign row_idx   = row_idx_q;
  assign buf_sel   = buf_sel_q;
  assign gen_count = gen_count_q;
  assign stable    = stable_q;

endmodule

// File: tb/tb_conway_ctrl.sv
// Directed bench for conway_ctrl with GRID_W=4, GEN_W=4.
// A small engine model answers row_start with row_done after eng_lat cycles;
// a display model acks disp_req after ack_dly extra cycles when enabled.

module tb_conway_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run_en;
  logic        step;
  logic        clear;
  logic [15:0] period;
  logic        row_done;
  logic        row_changed;
  logic        disp_ack;
  logic        row_start;
  logic [7:0]  row_idx;
  logic        buf_sel;
  logic        commit;
  logic        disp_req;
  logic [3:0]  gen_count;
  logic        stable;
  logic        busy;

  conway_ctrl #(.GRID_W(4), .PERIOD_W(16), .GEN_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_en      (run_en),
    .step        (step),
    .clear       (clear),
    .period      (period),
    .row_done    (row_done),
    .row_changed (row_changed),
    .disp_ack    (disp_ack),
    .row_start   (row_start),
    .row_idx     (row_idx),
    .buf_sel     (buf_sel),
    .commit      (commit),
    .disp_req    (disp_req),
    .gen_count   (gen_count),
    .stable      (stable),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // engine / display model controls
  int       eng_lat  = 1;
  logic [3:0] chg_mask = 4'b0000;
  logic     ack_en   = 1'b0;
  int       ack_dly  = 0;
  logic     man_ack  = 1'b0;
  logic     auto_ack = 1'b0;
  int       dcnt     = 0;
  int       last_disp_len = 0;

  assign disp_ack = man_ack | auto_ack;

  // monitor state
  int cyc  = 0;
  int cm_n = 0;
  int cm_last = 0;
  int rs_cyc[$];
  int rs_idx[$];
  int gq[$];
  logic prev_commit = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0: return commit;
      1: return disp_req;
      2: return !busy;
      default: return row_start;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int budget, input string tag);
    int n = 0;
    while (!cond(which) && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(cond(which)), 32'd1);
  endtask

  task automatic wait_commits(input int target, input int budget, input string tag);
    int n = 0;
    while (cm_n < target && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(cm_n >= target), 32'd1);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_commit) gq.push_back(int'(gen_count));
      prev_commit = commit;
      if (row_start) begin
        rs_cyc.push_back(cyc);
        rs_idx.push_back(int'(row_idx));
      end
      if (commit) begin
        cm_n++;
        cm_last = cyc;
      end
    end
  end

  // row engine model
  initial begin
    row_done    = 1'b0;
    row_changed = 1'b0;
    forever begin
      @(negedge clk);
      row_done    = 1'b0;
      row_changed = 1'b0;
      if (rst_n && row_start) begin
        logic chg;
        chg = chg_mask[row_idx[1:0]];
        repeat (eng_lat) @(negedge clk);
        row_done    = 1'b1;
        row_changed = chg;
      end
    end
  end

  // display model: ack on the (ack_dly+1)-th cycle of disp_req
  initial begin
    forever begin
      @(negedge clk);
      if (disp_req) dcnt++;
      else begin
        if (dcnt > 0) last_disp_len = dcnt;
        dcnt = 0;
      end
      auto_ack = ack_en && disp_req && (dcnt > ack_dly);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int c17;
    rst_n  = 1'b0;
    run_en = 1'b0;
    step   = 1'b0;
    clear  = 1'b0;
    period = 16'd0;
    repeat (3) tick();

    // reset state
    check_val("rst_flags", {26'd0, row_start, commit, disp_req, busy, stable, buf_sel}, 32'd0);
    check_val("rst_row_idx", 32'(row_idx), 32'd0);
    check_val("rst_gen", 32'(gen_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // single step, row 2 changed
    chg_mask = 4'b0100;
    eng_lat  = 1;
    ack_en   = 1'b0;
    rs_cyc.delete();
    rs_idx.delete();
    pulse_step();
    wait_cond(0, 50, "step_commit_seen");
    check_val("step_rs_count", 32'(rs_idx.size()), 32'd4);
    check_val("step_row_seq", {8'(rs_idx[0]), 8'(rs_idx[1]), 8'(rs_idx[2]), 8'(rs_idx[3])}, 32'h00010203);
    check_val("step_commit_lat", 32'(cm_last - rs_cyc[0]), 32'd8);
    tick();
    check_val("step_gen", 32'(gen_count), 32'd1);
    check_val("step_buf", 32'(buf_sel), 32'd1);
    check_val("step_stable", 32'(stable), 32'd0);
    repeat (5) tick();
    check_val("step_disp_held", 32'(disp_req), 32'd1);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check_val("step_idle", {30'd0, busy, disp_req}, 32'd0);

    // free run, period 3, immediate ack; run_en drops mid-generation 4
    chg_mask = 4'b1111;
    period   = 16'd3;
    ack_en   = 1'b1;
    ack_dly  = 0;
    rs_cyc.delete();
    gq.delete();
    base   = cm_n;
    run_en = 1'b1;
    wait_commits(base + 3, 200, "run_three_commits");
    wait_cond(3, 30, "run_gen4_start");
    run_en = 1'b0;
    wait_commits(base + 4, 60, "run_gen4_commit");
    wait_cond(2, 40, "run_back_idle");
    check_val("run_rs_total", 32'(rs_cyc.size()), 32'd16);
    check_val("run_gap_1_2", 32'(rs_cyc[4] - rs_cyc[0]), 32'd14);
    check_val("run_gap_3_4", 32'(rs_cyc[12] - rs_cyc[8]), 32'd14);
    check_val("run_gen_first", 32'(gq[0]), 32'd2);
    check_val("run_gen_last", 32'(gq[3]), 32'd5);

    // auto-halt: no changed rows
    chg_mask = 4'b0000;
    rs_cyc.delete();
    base   = cm_n;
    run_en = 1'b1;
    wait_commits(base + 1, 60, "halt_commit");
    tick();
    check_val("halt_stable", 32'(stable), 32'd1);
    wait_cond(2, 40, "halt_idle");
    repeat (20) tick();
    check_val("halt_stays_idle", {31'd0, busy}, 32'd0);
    check_val("halt_no_rows", 32'(rs_cyc.size()), 32'd4);
    pulse_step();
    wait_commits(base + 2, 60, "halt_step_commit");
    wait_cond(2, 40, "halt_step_idle");
    check_val("halt_step_rows", 32'(rs_cyc.size()), 32'd8);
    check_val("halt_step_gen", 32'(gen_count), 32'd7);
    run_en = 1'b0;

    // clear in DISP with disp_ack in the same cycle
    ack_en = 1'b0;
    pulse_step();
    wait_cond(1, 60, "clr_reach_disp");
    check_val("clr_pre_gen", 32'(gen_count), 32'd8);
    check_val("clr_pre_stable", 32'(stable), 32'd1);
    man_ack = 1'b1;
    clear   = 1'b1;
    tick();
    clear   = 1'b0;
    man_ack = 1'b0;
    check_val("clr_flags", {28'd0, busy, disp_req, buf_sel, stable}, 32'd0);
    check_val("clr_gen", 32'(gen_count), 32'd0);

    // counter wrap, then back-pressure on generation 17
    chg_mask = 4'b0001;
    period   = 16'd0;
    ack_en   = 1'b1;
    ack_dly  = 0;
    gq.delete();
    base   = cm_n;
    run_en = 1'b1;
    wait_commits(base + 17, 400, "wrap_17_commits");
    c17     = cm_last;
    ack_dly = 10;
    rs_cyc.delete();
    wait_cond(3, 40, "bp_next_start");
    check_val("bp_rs_gap", 32'(rs_cyc[0] - c17), 32'd13);
    check_val("bp_disp_len", 32'(last_disp_len), 32'd11);
    check_val("bp_rs_count", 32'(rs_cyc.size()), 32'd1);
    run_en = 1'b0;
    wait_commits(base + 18, 60, "bp_last_commit");
    wait_cond(2, 60, "bp_idle");
    check_val("wrap_gq_size", 32'(gq.size()), 32'd18);
    check_val("wrap_gen15", 32'(gq[14]), 32'd15);
    check_val("wrap_gen16", 32'(gq[15]), 32'd0);
    check_val("wrap_gen17", 32'(gq[16]), 32'd1);
    ack_dly = 0;

    // asynchronous reset mid-ROW_WAIT
    eng_lat = 3;
    pulse_step();
    repeat (5) tick();
    check_val("arst_pre_row", 32'(row_idx), 32'd1);
    check_val("arst_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("arst_flags", {26'd0, row_start, commit, disp_req, busy, stable, buf_sel}, 32'd0);
    check_val("arst_row_idx", 32'(row_idx), 32'd0);
    check_val("arst_gen", 32'(gen_count), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check_val("arst_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
